// File: rtl/io_mmio_controller.sv
// ----------------------------------------------------------------------------
// io_mmio_controller
//
// Purpose:
//   Memory-mapped IO controller sitting between the single-cycle core's data
//   port and the board IO. Decodes a 6-word window starting at word address
//   IO_BASE_ADDR, owns the LED and 7-segment registers that drive the output
//   bus, synchronizes switches and buttons, debounces the buttons and latches
//   button press events for software polling.
//
// Word map (offset from IO_BASE_ADDR):
//   0 LED      RW    [9:0]
//   1 HEX_LO   RW    [27:0] = {hex3, hex2, hex1, hex0}
//   2 HEX_HI   RW    [13:0] = {hex5, hex4}
//   3 SW       RO    [9:0]  synchronized switches
//   4 BTN      RO    [3:0]  debounced level, 1 = pressed
//   5 BTN_EVT  RW1C  [3:0]  sticky press events
//
// Ports:
//   clock          in   system clock, rising edge
//   reset          in   asynchronous, active-low reset
//   addr           in   byte address from the core (addr[1:0] ignored)
//   wdata          in   store data
//   write_enable   in   store strobe, valid with addr
//   io_sel         out  addr falls inside the IO window (combinational)
//   rdata          out  read data (combinational), 0 outside the window
//   io_input_bus   in   [9:0] switches, [13:10] raw buttons (asynchronous)
//   io_output_bus  out  [9:0] led, [16:10] hex0 ... [51:45] hex5
// ----------------------------------------------------------------------------
module io_mmio_controller #(
    parameter int XLEN              = 32,
    parameter int IO_INPUT_BUS_LEN  = 14,
    parameter int IO_OUTPUT_BUS_LEN = 52,
    parameter int IO_BASE_ADDR      = 'h15,
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int BTN_ACTIVE_LOW    = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [XLEN-1:0]              addr,
    input  logic [XLEN-1:0]              wdata,
    input  logic                         write_enable,
    output logic                         io_sel,
    output logic [XLEN-1:0]              rdata,
    input  logic [IO_INPUT_BUS_LEN-1:0]  io_input_bus,
    output logic [IO_OUTPUT_BUS_LEN-1:0] io_output_bus
);

    localparam int              AW          = XLEN - 2;
    localparam int              CW          = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [AW-1:0]   BASE_WORD   = AW'(IO_BASE_ADDR);
    localparam logic [AW-1:0]   WINDOW_SIZE = AW'(6);
    localparam logic [CW-1:0]   CNT_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam bit              BTN_INVERT  = (BTN_ACTIVE_LOW != 0);
    // Button sync flops come out of reset at the "released" raw level.
    localparam logic [IO_INPUT_BUS_LEN-1:0] SYNC_RST = BTN_INVERT ? {4'hF, 10'h000} : '0;

    // Register state
    logic [9:0]                  led_q,    led_d;
    logic [27:0]                 hex_lo_q, hex_lo_d;
    logic [13:0]                 hex_hi_q, hex_hi_d;
    logic [IO_INPUT_BUS_LEN-1:0] sync1_q,  sync1_d;
    logic [IO_INPUT_BUS_LEN-1:0] sync2_q,  sync2_d;
    logic [3:0]                  btn_db_q, btn_db_d;
    logic [CW-1:0]               cnt_q [4];
    logic [CW-1:0]               cnt_d [4];
    logic [3:0]                  evt_q,    evt_d;

    // Decode helpers
    logic [AW-1:0] off;
    logic [2:0]    off_idx;
    logic          wr_en;
    logic [3:0]    btn_sync;
    logic [3:0]    evt_clr;
    logic          unused_bits;

    // Offsets below the base wrap to large unsigned values, so a single
    // upper-bound compare covers both ends of the window.
    assign off     = addr[XLEN-1:2] - BASE_WORD;
    assign io_sel  = (off < WINDOW_SIZE);
    assign off_idx = off[2:0];
    assign wr_en   = write_enable & io_sel;

    assign btn_sync = BTN_INVERT ? ~sync2_q[13:10] : sync2_q[13:10];

    assign unused_bits = ^{addr[1:0], wdata[XLEN-1:28]};

    assign io_output_bus = {hex_hi_q, hex_lo_q, led_q};

    // Next-state logic: register writes, synchronizer shift, per-button
    // debounce counters and the sticky press-event bits.
    always_comb begin
        led_d    = led_q;
        hex_lo_d = hex_lo_q;
        hex_hi_d = hex_hi_q;
        sync1_d  = io_input_bus;
        sync2_d  = sync1_q;
        btn_db_d = btn_db_q;
        evt_clr  = 4'h0;

        if (wr_en) begin
            case (off_idx)
                3'd0:    led_d    = wdata[9:0];
                3'd1:    hex_lo_d = wdata[27:0];
                3'd2:    hex_hi_d = wdata[13:0];
                3'd5:    evt_clr  = wdata[3:0];
                default: ;
            endcase
        end

        // Counter only runs while the synced level disagrees with the
        // accepted level; any agreement snaps it back to zero.
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (btn_sync[i] != btn_db_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    btn_db_d[i] = btn_sync[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end

        // A new press on the same edge as a clear wins over the clear.
        evt_d = (evt_q & ~evt_clr) | (btn_db_d & ~btn_db_q);
    end

    // Zero-latency read mux straight from the registers.
    always_comb begin
        rdata = '0;
        if (io_sel) begin
            case (off_idx)
                3'd0:    rdata[9:0]  = led_q;
                3'd1:    rdata[27:0] = hex_lo_q;
                3'd2:    rdata[13:0] = hex_hi_q;
                3'd3:    rdata[9:0]  = sync2_q[9:0];
                3'd4:    rdata[3:0]  = btn_db_q;
                3'd5:    rdata[3:0]  = evt_q;
                default: rdata       = '0;
            endcase
        end
    end

    // State registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            led_q    <= '0;
            hex_lo_q <= '1;
            hex_hi_q <= '1;
            sync1_q  <= SYNC_RST;
            sync2_q  <= SYNC_RST;
            btn_db_q <= '0;
            evt_q    <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            led_q    <= led_d;
            hex_lo_q <= hex_lo_d;
            hex_hi_q <= hex_hi_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            btn_db_q <= btn_db_d;
            evt_q    <= evt_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_io_mmio_controller.sv
// ----------------------------------------------------------------------------
// tb_io_mmio_controller
//
// Directed bench for io_mmio_controller with hand-computed expected values.
// Inputs change on the falling edge; outputs are checked away from the
// rising edge.
// ----------------------------------------------------------------------------
module tb_io_mmio_controller;

    logic        clock;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write_enable;
    logic        io_sel;
    logic [31:0] rdata;
    logic [13:0] io_input_bus;
    logic [51:0] io_output_bus;

    int vectors;
    int miscompares;

    localparam logic [51:0] OUT_RST = 52'hFFFFFFFFFFC00;

    io_mmio_controller dut (
        .clock         (clock),
        .reset         (reset),
        .addr          (addr),
        .wdata         (wdata),
        .write_enable  (write_enable),
        .io_sel        (io_sel),
        .rdata         (rdata),
        .io_input_bus  (io_input_bus),
        .io_output_bus (io_output_bus)
    );

    // 10 ns clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One comparison: counts the vector and reports any miscompare.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Store one word; returns on the falling edge after the write edge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d);
        addr         = a;
        wdata        = d;
        write_enable = 1'b1;
        @(posedge clock);
        @(negedge clock);
        write_enable = 1'b0;
    endtask

    // Combinational read, checked 1 ns after driving the address.
    task automatic checkRead(input string tag, input logic [31:0] a, input logic [31:0] exp);
        write_enable = 1'b0;
        addr         = a;
        #1;
        checkOutput(tag, {32'h0, rdata}, {32'h0, exp});
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset        = 1'b0;
        addr         = 32'h0;
        wdata        = 32'h0;
        write_enable = 1'b0;
        io_input_bus = 14'h0;

        // Reset held with random inputs and stray stores
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            io_input_bus = 14'($urandom);
            addr         = 32'h54;
            wdata        = $urandom;
            write_enable = 1'b1;
        end
        @(negedge clock);
        #1;
        checkOutput("rst_outbus", {12'h0, io_output_bus}, {12'h0, OUT_RST});
        checkRead("rst_led",    32'h54, 32'h0000_0000);
        checkRead("rst_hex_lo", 32'h58, 32'h0FFF_FFFF);
        checkRead("rst_hex_hi", 32'h5C, 32'h0000_3FFF);
        checkRead("rst_sw",     32'h60, 32'h0000_0000);
        checkRead("rst_btn",    32'h64, 32'h0000_0000);
        checkRead("rst_evt",    32'h68, 32'h0000_0000);

        // Release with switches off and buttons released (high)
        @(negedge clock);
        io_input_bus = {4'hF, 10'h000};
        reset        = 1'b1;
        repeat (3) @(negedge clock);

        // Decode
        applyStimulus(32'h54, 32'hFFFF_F3A5);
        checkRead("led_rd", 32'h54, 32'h0000_03A5);
        checkOutput("led_bus", {54'h0, io_output_bus[9:0]}, 64'h3A5);
        addr = 32'h6C;
        #1;
        checkOutput("sel_off6", {63'h0, io_sel}, 64'h0);
        applyStimulus(32'h6C, 32'h0000_0000);
        #1;
        checkOutput("off6_nochg", {12'h0, io_output_bus}, {12'h0, 42'h3FF_FFFF_FFFF, 10'h3A5});
        checkRead("rd_off6", 32'h6C, 32'h0);
        addr = 32'h50;
        #1;
        checkOutput("sel_below", {63'h0, io_sel}, 64'h0);
        addr = 32'h68;
        #1;
        checkOutput("sel_off5", {63'h0, io_sel}, 64'h1);
        @(negedge clock);
        applyStimulus(32'h59, 32'h1234_5678);
        checkRead("hex_lo_rd", 32'h58, 32'h0234_5678);
        checkOutput("hex_lo_bus", {36'h0, io_output_bus[37:10]}, {36'h0, 28'h234_5678});
        applyStimulus(32'h5C, 32'hFFFF_2A55);
        checkRead("hex_hi_rd", 32'h5C, 32'h0000_2A55);
        checkOutput("hex_hi_bus", {50'h0, io_output_bus[51:38]}, {50'h0, 14'h2A55});

        // Switch synchronizer latency
        io_input_bus[9:0] = 10'h2C1;
        @(negedge clock);
        checkRead("sw_1cyc", 32'h60, 32'h0);
        @(negedge clock);
        checkRead("sw_2cyc", 32'h60, 32'h2C1);
        applyStimulus(32'h60, 32'h0);
        checkRead("sw_ro", 32'h60, 32'h2C1);

        // Bounce btn0 low for 5 cycles: must be rejected
        io_input_bus[10] = 1'b0;
        repeat (5) @(negedge clock);
        io_input_bus[10] = 1'b1;
        repeat (25) @(negedge clock);
        checkRead("bounce_btn", 32'h64, 32'h0);
        checkRead("bounce_evt", 32'h68, 32'h0);

        // Hold btn0 low: accepted on the 18th rising edge
        io_input_bus[10] = 1'b0;
        repeat (17) @(negedge clock);
        checkRead("press_early", 32'h64, 32'h0);
        @(negedge clock);
        checkRead("press_btn", 32'h64, 32'h1);
        checkRead("press_evt", 32'h68, 32'h1);

        // Release: level drops, event stays
        io_input_bus[10] = 1'b1;
        repeat (20) @(negedge clock);
        checkRead("rel_btn", 32'h64, 32'h0);
        checkRead("rel_evt", 32'h68, 32'h1);

        // W1C clear on the same edge as a new press: set wins
        io_input_bus[10] = 1'b0;
        repeat (17) @(negedge clock);
        checkRead("race_pre", 32'h64, 32'h0);
        applyStimulus(32'h68, 32'h0000_0001);
        checkRead("race_btn", 32'h64, 32'h1);
        checkRead("race_evt", 32'h68, 32'h1);
        applyStimulus(32'h68, 32'hFFFF_FFF0);
        checkRead("w0_evt", 32'h68, 32'h1);
        applyStimulus(32'h68, 32'h0000_0001);
        checkRead("w1c_evt", 32'h68, 32'h0);

        // Asynchronous reset in the middle of a release count
        applyStimulus(32'h54, 32'h0000_03FF);
        checkOutput("led_3ff", {54'h0, io_output_bus[9:0]}, 64'h3FF);
        io_input_bus[10] = 1'b1;
        repeat (5) @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_bus", {12'h0, io_output_bus}, {12'h0, OUT_RST});
        checkRead("async_btn", 32'h64, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        repeat (25) @(negedge clock);
        checkRead("post_evt", 32'h68, 32'h0);
        checkRead("post_btn", 32'h64, 32'h0);
        checkRead("post_sw",  32'h60, 32'h2C1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
